me_window_fetch: RTL

Parametrised fetch engine for the 3DRS motion estimator: it walks a frame block by block and reads pixels from frame memory. For each block it loads the current (reference) block column by column into the core's current-block buffer. It then loads the search window with mirror padding at the frame edges, reusing the overlap between horizontally adjacent windows, and packs the window into interleaved 64-bit beats. It sits between frame memory and the ME core's `cur_*`/`search_*` write ports, replacing host-driven window loading, and sequences with the core through `curfilled`/`srcfilled`/`blockend`.

---
 rtl/me_window_fetch.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/me_window_fetch.sv
// me_window_fetch: walks a frame block by block, loads the current block
// column by column into the ME core's current-block buffer, then loads the
// mirror-padded search window as interleaved 64-bit beats. Horizontally
// adjacent windows share SW-BLK columns, so only the first block of a row
// loads the full window.
//
// Handshake with the core: curfilled / srcfilled are single-cycle "valid"
// pulses with no back-pressure. blockend is the core's "ready for the next
// block" and is only taken in WAIT_BLK; it is ignored in every other state.
module me_window_fetch #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720,
  parameter int BLK   = 16,
  parameter int PAD   = 36,
  parameter int AW    = 20,
  localparam int SW = BLK + 2 * PAD,
  localparam int Q  = SW / 4,
  localparam int NB = Q / 2,
  localparam int BX = IMG_W / BLK,
  localparam int BY = IMG_H / BLK,
  localparam int CW = (BLK > 1) ? $clog2(BLK) : 1,
  localparam int UW = $clog2(SW),
  localparam int KW = (NB > 1) ? $clog2(NB) : 1,
  localparam int XW = (BX > 1) ? $clog2(BX) : 1,
  localparam int YW = (BY > 1) ? $clog2(BY) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              frm_rd_en,
  output logic              frm_rd_sel,
  output logic [AW-1:0]     frm_rd_addr,
  input  logic [7:0]        frm_rd_data,
  output logic              cur_WE,
  output logic [CW-1:0]     cur_addr,
  output logic [8*BLK-1:0]  cur_data,
  output logic              curfilled,
  output logic              search_WE,
  output logic [UW-1:0]     search_col,
  output logic [KW-1:0]     search_beat,
  output logic [63:0]       search_data,
  output logic              srcfilled,
  input  logic              blockend,
  output logic              busy,
  output logic              frame_done,
  output logic [XW-1:0]     blk_x,
  output logic [YW-1:0]     blk_y,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REF       = 3'd1,
    REF_DRAIN = 3'd2,
    SRC       = 3'd3,
    SRC_DRAIN = 3'd4,
    WAIT_BLK  = 3'd5
  } state_t;

  localparam logic [CW-1:0] C_MAX = CW'(BLK - 1);
  localparam logic [UW-1:0] U_MAX = UW'(SW - 1);
  localparam logic [KW-1:0] K_MAX = KW'(NB - 1);
  localparam logic [XW-1:0] X_MAX = XW'(BX - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(BY - 1);

  state_t state;

  // Counters describing the read currently on the frame-memory bus
  logic [CW-1:0] ref_c, ref_r;
  logic [UW-1:0] src_u;
  logic [KW-1:0] src_k;
  logic [2:0]    src_i;

  // Tags of the read whose data is on frm_rd_data this cycle
  logic          ret_valid, ret_last, ret_sel;
  logic [CW-1:0] ret_c;
  logic [UW-1:0] ret_u;
  logic [KW-1:0] ret_k;
  logic [8*BLK-9:0] cur_shift;
  logic [55:0]      src_shift;

  logic [CW-1:0] ref_c_nx, ref_r_nx;
  logic [UW-1:0] src_u_nx, src_u0;
  logic [KW-1:0] src_k_nx;
  logic [2:0]    src_i_nx;
  logic [XW-1:0] nbx;
  logic [YW-1:0] nby;
  logic          ref_last, src_last, frame_last;

  assign fsm_state = state;

  // Padded coordinate -> image coordinate, reflecting about the frame edge
  function automatic int mirror(input int p, input int n);
    int m;
    if (p < PAD)          m = PAD - 1 - p;
    else if (p >= n + PAD) m = 2 * n + PAD - 1 - p;
    else                  m = p - PAD;
    return m;
  endfunction

  function automatic logic [AW-1:0] ref_addr(input int bx, input int by, input int c, input int r);
    return AW'((by * BLK + r) * IMG_W + bx * BLK + c);
  endfunction

  // Beat k reads window rows j+3Q, j+2Q, j+Q, j, then the same plus one (j = 2k)
  function automatic logic [AW-1:0] src_addr(input int bx, input int by, input int u, input int k,
                                             input int i);
    int v;
    int row;
    int col;
    if (i < 4) v = 2 * k + (3 - i) * Q;
    else       v = 2 * k + (7 - i) * Q + 1;
    row = mirror(by * BLK + v, IMG_H);
    col = mirror(bx * BLK + u, IMG_W);
    return AW'(row * IMG_W + col);
  endfunction

  // Next read position and next block coordinates
  always_comb begin
    ref_r_nx = ref_r + CW'(1);
    ref_c_nx = ref_c;
    if (ref_r == C_MAX) begin
      ref_r_nx = '0;
      ref_c_nx = ref_c + CW'(1);
    end
    src_i_nx = src_i + 3'd1;
    src_k_nx = src_k;
    src_u_nx = src_u;
    if (src_i == 3'd7) begin
      src_k_nx = src_k + KW'(1);
      if (src_k == K_MAX) begin
        src_k_nx = '0;
        src_u_nx = src_u + UW'(1);
      end
    end
    ref_last   = (ref_c == C_MAX) && (ref_r == C_MAX);
    src_last   = (src_u == U_MAX) && (src_k == K_MAX) && (src_i == 3'd7);
    src_u0     = (blk_x == '0) ? '0 : UW'(SW - BLK);
    frame_last = (blk_x == X_MAX) && (blk_y == Y_MAX);
    nbx = (blk_x == X_MAX) ? '0 : blk_x + XW'(1);
    nby = blk_y;
    if (blk_x == X_MAX) nby = (blk_y == Y_MAX) ? '0 : blk_y + YW'(1);
  end

  // Return path: shift returned pixels in at the LSByte and emit full columns/beats
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_valid   <= 1'b0;
      ret_last    <= 1'b0;
      ret_sel     <= 1'b0;
      ret_c       <= '0;
      ret_u       <= '0;
      ret_k       <= '0;
      cur_shift   <= '0;
      src_shift   <= '0;
      cur_WE      <= 1'b0;
      cur_addr    <= '0;
      cur_data    <= '0;
      search_WE   <= 1'b0;
      search_col  <= '0;
      search_beat <= '0;
      search_data <= '0;
    end else begin
      ret_valid <= frm_rd_en;
      ret_sel   <= frm_rd_sel;
      ret_last  <= frm_rd_sel ? (src_i == 3'd7) : (ref_r == C_MAX);
      ret_c     <= ref_c;
      ret_u     <= src_u;
      ret_k     <= src_k;
      cur_WE    <= 1'b0;
      search_WE <= 1'b0;
      if (ret_valid) begin
        if (ret_sel) begin
          src_shift <= {src_shift[47:0], frm_rd_data};
          if (ret_last) begin
            search_WE   <= 1'b1;
            search_col  <= ret_u;
            search_beat <= ret_k;
            search_data <= {src_shift, frm_rd_data};
          end
        end else begin
          cur_shift <= {cur_shift[8*BLK-17:0], frm_rd_data};
          if (ret_last) begin
            cur_WE   <= 1'b1;
            cur_addr <= ret_c;
            cur_data <= {cur_shift, frm_rd_data};
          end
        end
      end
    end
  end

  // Sequencer: issues one read per cycle per phase and steps through the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      curfilled   <= 1'b0;
      srcfilled   <= 1'b0;
      frm_rd_en   <= 1'b0;
      frm_rd_sel  <= 1'b0;
      frm_rd_addr <= '0;
      blk_x       <= '0;
      blk_y       <= '0;
      ref_c       <= '0;
      ref_r       <= '0;
      src_u       <= '0;
      src_k       <= '0;
      src_i       <= '0;
    end else begin
      curfilled  <= 1'b0;
      srcfilled  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          blk_x       <= '0;
          blk_y       <= '0;
          busy        <= 1'b1;
          ref_c       <= '0;
          ref_r       <= '0;
          frm_rd_en   <= 1'b1;
          frm_rd_sel  <= 1'b0;
          frm_rd_addr <= ref_addr(0, 0, 0, 0);
          state       <= REF;
        end
        REF: if (ref_last) begin
          frm_rd_en <= 1'b0;
          state     <= REF_DRAIN;
        end else begin
          ref_c       <= ref_c_nx;
          ref_r       <= ref_r_nx;
          frm_rd_addr <= ref_addr(int'(blk_x), int'(blk_y), int'(ref_c_nx), int'(ref_r_nx));
        end
        REF_DRAIN: begin
          if (cur_WE) curfilled <= 1'b1;
          if (curfilled) begin
            src_u       <= src_u0;
            src_k       <= '0;
            src_i       <= '0;
            frm_rd_en   <= 1'b1;
            frm_rd_sel  <= 1'b1;
            frm_rd_addr <= src_addr(int'(blk_x), int'(blk_y), int'(src_u0), 0, 0);
            state       <= SRC;
          end
        end
        SRC: if (src_last) begin
          frm_rd_en <= 1'b0;
          state     <= SRC_DRAIN;
        end else begin
          src_u       <= src_u_nx;
          src_k       <= src_k_nx;
          src_i       <= src_i_nx;
          frm_rd_addr <= src_addr(int'(blk_x), int'(blk_y), int'(src_u_nx), int'(src_k_nx),
                                  int'(src_i_nx));
        end
        SRC_DRAIN: begin
          if (search_WE) srcfilled <= 1'b1;
          if (srcfilled) state <= WAIT_BLK;
        end
        WAIT_BLK: if (blockend) begin
          blk_x <= nbx;
          blk_y <= nby;
          if (frame_last) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            ref_c       <= '0;
            ref_r       <= '0;
            frm_rd_en   <= 1'b1;
            frm_rd_sel  <= 1'b0;
            frm_rd_addr <= ref_addr(int'(nbx), int'(nby), 0, 0);
            state       <= REF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
